// File: rtl/dac_drv_pkg.sv
// Shared constants and state encoding for the DAC segment encoder.
// Thermometer width and binary split are fixed here for the whole path.
package dac_drv_pkg;

    localparam int BIN_W    = 8;
    localparam int THERM_W  = 17;
    localparam int CODE_W   = 13;
    localparam int CODE_MAX = 4607;
    localparam int K_W      = CODE_W - BIN_W;
    localparam int PTR_W    = 5;

    localparam logic [CODE_W-1:0] CODE_LIM = CODE_W'(CODE_MAX);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/dac_segment_encoder_therm_rot_decoder.sv
// Thermometer decoder: k ones starting at ptr, wrapping modulo THERM_W.
// With ptr tied to zero this is a plain bottom-filled thermometer.
module therm_rot_decoder
    import dac_drv_pkg::*;
(
    input  logic [K_W-1:0]     k,
    input  logic [PTR_W-1:0]   ptr,
    output logic [THERM_W-1:0] therm
);

    logic [5:0] off;

    // Bit i is set when its distance above ptr (mod THERM_W) is below k.
    always_comb begin
        therm = '0;
        off   = '0;
        for (int i = 0; i < THERM_W; i++) begin
            if (5'(i) >= ptr) begin
                off = 6'(i) - {1'b0, ptr};
            end else begin
                off = 6'(i + THERM_W) - {1'b0, ptr};
            end
            therm[i] = (off < {1'b0, k});
        end
    end

endmodule

// File: rtl/dac_segment_encoder.sv
// Segment encoder ahead of driver_cell: power sequencing and code split.
// Optional DAC_DEM_DWA_EN enables data-weighted averaging rotation.
module dac_segment_encoder
    import dac_drv_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CODE_W-1:0]  code,
    input  logic               code_valid,
    output logic               code_ready,
    output logic               pdb,
    output logic [BIN_W-1:0]   datain,
    output logic [BIN_W-1:0]   datainb,
    output logic [THERM_W-1:0] datatherm,
    output logic [THERM_W-1:0] datathermb,
    output logic               sat
);

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         cnt;
    logic [7:0]         cnt_nxt;
    logic               accept;
    logic               s1_valid;
    logic [CODE_W-1:0]  s1_code;
    logic [K_W-1:0]     k;
    logic [PTR_W-1:0]   ptr;
    logic [THERM_W-1:0] therm;

    assign accept = code_valid & code_ready;
    assign k      = s1_code[CODE_W-1:BIN_W];

    // Power sequencing: en low always wins and parks the block in OFF.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                OFF: begin
                    state_nxt = WAKE;
                    cnt_nxt   = '0;
                end
                WAKE: begin
                    if (cnt == 8'(SETTLE_CYC - 1)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                RUN: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, settle counter and registered pdb / code_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OFF;
            cnt        <= '0;
            pdb        <= 1'b0;
            code_ready <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pdb        <= (state_nxt != OFF);
            code_ready <= (state_nxt == RUN);
        end
    end

    // Stage 1: capture and clamp the accepted code, flag saturation.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            sat      <= 1'b0;
        end else begin
            s1_valid <= accept;
            sat      <= accept && (code > CODE_LIM);
            if (accept) begin
                s1_code <= (code > CODE_LIM) ? CODE_LIM : code;
            end
        end
    end

    therm_rot_decoder u_dec (
        .k     (k),
        .ptr   (ptr),
        .therm (therm)
    );

    // Stage 2: drive true and complement outputs from the same flops edge.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            datain     <= '0;
            datainb    <= '1;
            datatherm  <= '0;
            datathermb <= '1;
        end else if (s1_valid) begin
            datain     <= s1_code[BIN_W-1:0];
            datainb    <= ~s1_code[BIN_W-1:0];
            datatherm  <= therm;
            datathermb <= ~therm;
        end
    end

`ifdef DAC_DEM_DWA_EN
    logic [5:0] ptr_sum;
    logic [5:0] ptr_wrap;

    // Next rotation pointer: advance by k, wrapping modulo THERM_W.
    always_comb begin
        ptr_sum  = {1'b0, ptr} + {1'b0, k};
        ptr_wrap = ptr_sum;
        if (ptr_sum >= 6'(THERM_W)) begin
            ptr_wrap = ptr_sum - 6'(THERM_W);
        end
    end

    // Pointer advances with every stage-2 update, clears when powered down.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            ptr <= '0;
        end else if (s1_valid) begin
            ptr <= ptr_wrap[PTR_W-1:0];
        end
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Directed bench for dac_segment_encoder with hand-computed vectors.
// Thermometer expectations switch to rotated values under DAC_DEM_DWA_EN.
module tb_dac_segment_encoder;
    import dac_drv_pkg::*;

`ifdef DAC_DEM_DWA_EN
    localparam bit DWA = 1'b1;
`else
    localparam bit DWA = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [CODE_W-1:0]  code;
    logic               code_valid;
    logic               code_ready;
    logic               pdb;
    logic [BIN_W-1:0]   datain;
    logic [BIN_W-1:0]   datainb;
    logic [THERM_W-1:0] datatherm;
    logic [THERM_W-1:0] datathermb;
    logic               sat;

    int checks = 0;
    int errors = 0;

    dac_segment_encoder #(.SETTLE_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pdb        (pdb),
        .datain     (datain),
        .datainb    (datainb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [BIN_W-1:0] din,
                            input logic [THERM_W-1:0] th);
        logic [BIN_W-1:0]   dinb;
        logic [THERM_W-1:0] thb;
        dinb = ~din;
        thb  = ~th;
        chk({tag, ".datain"}, {24'd0, datain}, {24'd0, din});
        chk({tag, ".datainb"}, {24'd0, datainb}, {24'd0, dinb});
        chk({tag, ".therm"}, {15'd0, datatherm}, {15'd0, th});
        chk({tag, ".thermb"}, {15'd0, datathermb}, {15'd0, thb});
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        code_valid = 1'b0;
        code       = '0;
        tick();
        tick();
        chk("rst.pdb", {31'd0, pdb}, 32'd0);
        chk("rst.ready", {31'd0, code_ready}, 32'd0);
        chk("rst.sat", {31'd0, sat}, 32'd0);
        chk_data("rst", 8'h00, 17'h00000);

        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk("wake.pdb", {31'd0, pdb}, 32'd1);
        chk("wake.ready", {31'd0, code_ready}, 32'd0);
        chk_data("wake", 8'h00, 17'h00000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wake.ready_n", {31'd0, code_ready}, 32'd0);
            chk("wake.pdb_n", {31'd0, pdb}, 32'd1);
            chk_data("wake_n", 8'h00, 17'h00000);
        end
        tick();
        chk("run.ready", {31'd0, code_ready}, 32'd1);
        chk_data("run", 8'h00, 17'h00000);

        code_valid = 1'b1;
        code       = 13'd768;
        tick();
        chk_data("dwa_lat", 8'h00, 17'h00000);
        code = 13'd768;
        tick();
        chk_data("dwa_a", 8'h00, 17'h00007);
        code = 13'd4352;
        tick();
        chk_data("dwa_b", 8'h00, DWA ? 17'h00038 : 17'h00007);
        code = 13'd256;
        tick();
        chk_data("dwa_c", 8'h00, 17'h1FFFF);
        code_valid = 1'b0;
        tick();
        chk_data("ptr_probe", 8'h00, DWA ? 17'h00040 : 17'h00001);

        code_valid = 1'b1;
        code       = 13'd1000;
        tick();
        chk_data("stream0", 8'h00, DWA ? 17'h00040 : 17'h00001);
        code = 13'd2000;
        tick();
        chk_data("stream1", 8'hE8, DWA ? 17'h00380 : 17'h00007);
        en   = 1'b0;
        code = 13'd3000;
        tick();
        chk("drop.pdb", {31'd0, pdb}, 32'd0);
        chk("drop.ready", {31'd0, code_ready}, 32'd0);
        chk("drop.sat", {31'd0, sat}, 32'd0);
        chk_data("drop", 8'h00, 17'h00000);
        tick();
        tick();
        chk_data("drop2", 8'h00, 17'h00000);

        en = 1'b1;
        tick();
        chk("rewake.pdb", {31'd0, pdb}, 32'd1);
        chk("rewake.ready", {31'd0, code_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rewake.ready_n", {31'd0, code_ready}, 32'd0);
            chk_data("rewake_n", 8'h00, 17'h00000);
        end
        tick();
        chk("rewake.run", {31'd0, code_ready}, 32'd1);
        chk_data("rewake_run", 8'h00, 17'h00000);
        tick();
        chk_data("rewake_lat", 8'h00, 17'h00000);
        code_valid = 1'b0;
        tick();
        chk_data("rewake_out", 8'hB8, 17'h007FF);

        code_valid = 1'b1;
        code       = 13'd0;
        tick();
        chk("c0.sat", {31'd0, sat}, 32'd0);
        code = 13'd300;
        tick();
        chk_data("c0", 8'h00, 17'h00000);
        code = 13'd4607;
        tick();
        chk_data("c300", 8'h2C, DWA ? 17'h00800 : 17'h00001);
        chk("max.sat", {31'd0, sat}, 32'd0);
        code_valid = 1'b0;
        tick();
        chk_data("c4607", 8'hFF, 17'h1FFFF);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk_data("hold", 8'hFF, 17'h1FFFF);
            chk("hold.sat", {31'd0, sat}, 32'd0);
        end

        code_valid = 1'b1;
        code       = 13'd513;
        tick();
        code = 13'd5000;
        tick();
        chk("sat5000", {31'd0, sat}, 32'd1);
        chk_data("c513", 8'h01, DWA ? 17'h03000 : 17'h00003);
        code = 13'd4608;
        tick();
        chk("sat4608", {31'd0, sat}, 32'd1);
        chk_data("c5000", 8'hFF, 17'h1FFFF);
        code_valid = 1'b0;
        tick();
        chk("sat_clear", {31'd0, sat}, 32'd0);
        chk_data("c4608", 8'hFF, 17'h1FFFF);
        tick();
        chk("sat_idle", {31'd0, sat}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
